// File: rtl/power_telemetry_pkg.sv
// Shared telemetry types: integrator FSM states, accumulator widths and a small max helper.
package power_telemetry_pkg;
    localparam int ENERGY_W = 48;
    localparam int CNT_W    = 32;
    localparam int PWR_W    = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } pti_state_t;

    function automatic logic [PWR_W-1:0] pwr_max(input logic [PWR_W-1:0] a,
                                                 input logic [PWR_W-1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/sat_accum.sv
// Saturating adder-register with clear (clear wins over add) and sticky saturation flag.
// Result visible one cycle after i_add; no backpressure.
module sat_accum #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clr,
    input  logic         i_add,
    input  logic [W-1:0] i_addend,
    output logic [W-1:0] o_acc,
    output logic         o_sat
);
    logic [W:0]   w_sum;
    logic [W-1:0] w_acc_nxt;
    logic         w_sat_nxt;
    logic [W-1:0] r_acc;
    logic         r_sat;

    always_comb begin
        w_sum     = {1'b0, r_acc} + {1'b0, i_addend};
        w_acc_nxt = r_acc;
        w_sat_nxt = r_sat;
        if (i_clr) begin
            w_acc_nxt = '0;
            w_sat_nxt = 1'b0;
        end else if (i_add) begin
            if (w_sum[W]) begin
                w_acc_nxt = '1;
                w_sat_nxt = 1'b1;
            end else begin
                w_acc_nxt = w_sum[W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_sat <= w_sat_nxt;
        end
    end

    assign o_acc = r_acc;
    assign o_sat = r_sat;
endmodule

// File: rtl/power_energy_integrator.sv
// Integrates sampled power into energy, tracks window avg/peak and budget overruns, offers a held snapshot.
// Sample results visible with sample_tick; snapshot held until snap_ready (valid/ready, no data loss).
import power_telemetry_pkg::*;

module power_energy_integrator #(
    parameter int CLK_MHZ     = 100,
    parameter int SAMPLE_US   = 1,
    parameter int WINDOW_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [PWR_W-1:0]    current_power_mw,
    input  logic [PWR_W-1:0]    leakage_power_mw,
    input  logic [PWR_W-1:0]    power_budget,
    input  logic                snap_req,
    input  logic                snap_ready,
    output logic [ENERGY_W-1:0] energy_nj,
    output logic [ENERGY_W-1:0] leak_energy_nj,
    output logic [CNT_W-1:0]    sample_cnt,
    output logic                sample_tick,
    output logic [PWR_W-1:0]    avg_power_mw,
    output logic [PWR_W-1:0]    peak_power_mw,
    output logic                avg_valid,
    output logic [PWR_W-1:0]    over_budget_cnt,
    output logic                energy_sat,
    output logic                snap_valid,
    output logic [ENERGY_W-1:0] snap_energy_nj,
    output logic [CNT_W-1:0]    snap_sample_cnt
);
    localparam int DIV   = CLK_MHZ * SAMPLE_US;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WC_W  = (WINDOW_LOG2 > 0) ? WINDOW_LOG2 : 1;
    localparam int SUM_W = PWR_W + WINDOW_LOG2;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [WC_W-1:0]  WIN_LAST = WC_W'((1 << WINDOW_LOG2) - 1);

    pti_state_t          r_state;
    pti_state_t          w_state_nxt;
    logic                w_snap_take;
    logic                w_run;
    logic                w_sample;
    logic [DIV_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_tick;
    logic [ENERGY_W-1:0] w_e_add;
    logic [ENERGY_W-1:0] w_l_add;
    logic                w_sat_e;
    logic                w_sat_l;
    logic [SUM_W-1:0]    r_win_sum;
    logic [SUM_W-1:0]    w_sum_nxt;
    logic [PWR_W-1:0]    r_win_peak;
    logic [PWR_W-1:0]    w_peak_nxt;
    logic [WC_W-1:0]     r_win_cnt;
    logic [PWR_W-1:0]    r_avg;
    logic [PWR_W-1:0]    r_peak;
    logic                r_avg_vld;
    logic [PWR_W-1:0]    r_over;
    logic                r_snap_vld;
    logic                r_snap_fresh;
    logic [ENERGY_W-1:0] r_snap_e;
    logic [CNT_W-1:0]    r_snap_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_snap_take = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (snap_req) begin
                    w_state_nxt = S_HOLD;
                    w_snap_take = 1'b1;
                end else if (enable) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (snap_req) begin
                    w_state_nxt = S_HOLD;
                    w_snap_take = 1'b1;
                end else if (!enable) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (r_snap_vld && snap_ready) begin
                    w_state_nxt = enable ? S_RUN : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    assign w_run    = enable && ((r_state == S_RUN) || (r_state == S_HOLD));
    assign w_sample = w_run && (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div  <= '0;
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_sample && !clear;
            if (clear || !w_run || w_sample) r_div <= '0;
            else                             r_div <= r_div + DIV_W'(1);
            if (clear)         r_cnt <= '0;
            else if (w_sample) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_e_add = ENERGY_W'(current_power_mw) * ENERGY_W'(SAMPLE_US);
    assign w_l_add = ENERGY_W'(leakage_power_mw) * ENERGY_W'(SAMPLE_US);

    sat_accum #(.W(ENERGY_W)) u_energy (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (clear),
        .i_add    (w_sample),
        .i_addend (w_e_add),
        .o_acc    (energy_nj),
        .o_sat    (w_sat_e)
    );

    sat_accum #(.W(ENERGY_W)) u_leak (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (clear),
        .i_add    (w_sample),
        .i_addend (w_l_add),
        .o_acc    (leak_energy_nj),
        .o_sat    (w_sat_l)
    );

    assign w_sum_nxt  = r_win_sum + SUM_W'(current_power_mw);
    assign w_peak_nxt = pwr_max(r_win_peak, current_power_mw);

    // Window state deliberately ignores enable so a partial window survives a pause.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_win_sum  <= '0;
            r_win_peak <= '0;
            r_win_cnt  <= '0;
            r_avg      <= '0;
            r_peak     <= '0;
            r_avg_vld  <= 1'b0;
            r_over     <= '0;
        end else begin
            r_avg_vld <= 1'b0;
            if (w_sample) begin
                if (r_win_cnt == WIN_LAST) begin
                    r_avg      <= w_sum_nxt[SUM_W-1:WINDOW_LOG2];
                    r_peak     <= w_peak_nxt;
                    r_avg_vld  <= 1'b1;
                    r_win_sum  <= '0;
                    r_win_peak <= '0;
                    r_win_cnt  <= '0;
                end else begin
                    r_win_sum  <= w_sum_nxt;
                    r_win_peak <= w_peak_nxt;
                    r_win_cnt  <= r_win_cnt + WC_W'(1);
                end
                if ((power_budget != '0) && (current_power_mw > power_budget) &&
                    (r_over != '1)) begin
                    r_over <= r_over + PWR_W'(1);
                end
            end
        end
    end

    // The capture edge itself may update the counters, so the snapshot shows the live
    // registers for one cycle (r_snap_fresh) and latches them on the following edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_snap_vld   <= 1'b0;
            r_snap_fresh <= 1'b0;
            r_snap_e     <= '0;
            r_snap_cnt   <= '0;
        end else begin
            r_snap_fresh <= w_snap_take;
            if (r_snap_fresh) begin
                r_snap_e   <= energy_nj;
                r_snap_cnt <= r_cnt;
            end
            if (w_snap_take)                    r_snap_vld <= 1'b1;
            else if (r_snap_vld && snap_ready)  r_snap_vld <= 1'b0;
        end
    end

    assign sample_cnt      = r_cnt;
    assign sample_tick     = r_tick;
    assign avg_power_mw    = r_avg;
    assign peak_power_mw   = r_peak;
    assign avg_valid       = r_avg_vld;
    assign over_budget_cnt = r_over;
    assign energy_sat      = w_sat_e | w_sat_l;
    assign snap_valid      = r_snap_vld;
    assign snap_energy_nj  = r_snap_fresh ? energy_nj : r_snap_e;
    assign snap_sample_cnt = r_snap_fresh ? r_cnt : r_snap_cnt;
endmodule

// File: doc/power_energy_integrator.md
POWER_ENERGY_INTEGRATOR -- requirements
Module: power_energy_integrator

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 100, the clk frequency in MHz.
REQ-002 SHALL have parameter SAMPLE_US, default 1, the sample period in microseconds; divider length DIV = CLK_MHZ*SAMPLE_US cycles.
REQ-003 SHALL have parameter WINDOW_LOG2, default 4; an averaging window is 2^WINDOW_LOG2 samples.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  run integration.
- clear  in  1  synchronous clear of accumulators.
- current_power_mw  in  16  total power from the power manager.
- leakage_power_mw  in  16  leakage component.
- power_budget  in  16  mW; 0 disables the budget check.
- snap_req  in  1  snapshot request pulse.
- snap_ready  in  1  consumer accepts the snapshot.
- energy_nj  out  48  live total energy.
- leak_energy_nj  out  48  live leakage energy.
- sample_cnt  out  32  samples taken.
- sample_tick  out  1  one-cycle pulse per sample.
- avg_power_mw  out  16  last window average.
- peak_power_mw  out  16  last window peak.
- avg_valid  out  1  one-cycle pulse when a window closes.
- over_budget_cnt  out  16  samples above budget.
- energy_sat  out  1  sticky flag, energy saturated.
- snap_valid  out  1  snapshot held.
- snap_energy_nj  out  48  frozen energy_nj.
- snap_sample_cnt  out  32  frozen sample_cnt.

Function
REQ-005 SHALL implement FSM states IDLE, RUN and HOLD.
- IDLE->RUN when enable=1; RUN->IDLE when enable=0.
- IDLE or RUN -> HOLD on snap_req.
- HOLD exits on snap_valid&&snap_ready, to RUN if enable=1, else to IDLE.
REQ-006 SHALL run the divider 0..DIV-1 only while enable=1 (in RUN, or HOLD with enable=1); it wraps to 0 and resets to 0 when enable=0.
REQ-007 SHALL treat the cycle with divider==DIV-1 as the sample cycle. At that edge it SHALL add current_power_mw*SAMPLE_US to energy_nj, add leakage_power_mw*SAMPLE_US to leak_energy_nj, increment sample_cnt and assert sample_tick for one cycle; updated values are visible with sample_tick.
REQ-008 SHALL saturate both energy accumulators at 2^48-1 and set energy_sat, which stays set until clear or reset; sample_cnt SHALL wrap at 2^32.
REQ-009 SHALL maintain the window per sample:
- window sum is (16+WINDOW_LOG2) bits; window peak = max of samples.
- on the 2^WINDOW_LOG2-th sample: avg_power_mw = sum>>WINDOW_LOG2 (truncating), peak_power_mw = window peak including that sample, avg_valid pulses for one cycle, and sum, peak and count restart at zero.
REQ-010 SHALL keep a partial window across enable=0 and resume it when enable returns.
REQ-011 SHALL increment over_budget_cnt on a sample when power_budget!=0 and current_power_mw>power_budget (strict), saturating at 0xFFFF.
REQ-012 SHALL, on snap_req accepted in IDLE or RUN, load snap_energy_nj and snap_sample_cnt with post-edge values (including any same-cycle sample) and assert snap_valid on the next cycle.
REQ-013 SHALL hold snap_valid and the snap_* outputs stable until snap_ready. snap_req in HOLD is ignored. snap_valid deasserts the cycle after the handshake. A new snap_req in the handshake cycle is ignored.
REQ-014 SHALL let clear zero energy_nj, leak_energy_nj, sample_cnt, window state, avg_power_mw, peak_power_mw, over_budget_cnt, energy_sat and the divider. Clear has priority over a coincident sample. Clear SHALL NOT alter FSM state, snap_valid or the snap_* outputs.

Reset
REQ-015 SHALL, with reset_n=0 at a clk edge, force every output to 0, the FSM to IDLE and the divider and window to 0, aborting any pending snapshot; reset has priority over all inputs.

Structure
REQ-016 SHALL place the FSM state enum, ENERGY_W=48 and CNT_W=32 in shared package power_telemetry_pkg.
REQ-017 SHALL instantiate sub-module sat_accum (width-parameterised saturating adder-register with clear and sat flag) twice, once per energy accumulator.

Verification
REQ-018 SHALL cover these directed scenarios:
- Constant 1000 mW, leak 200, enable for 10 samples (1000 cycles) -> energy_nj=10000, leak_energy_nj=2000, sample_cnt=10.
- Power ramp 100..1600 step 100 over 16 samples -> avg_valid pulse, avg_power_mw=850, peak_power_mw=1600.
- Budget 500; 5 samples at 600 then 5 at 400 -> over_budget_cnt=5; budget 0 with 600 mW -> count unchanged.
- snap_req after 3 samples with snap_ready low for 500 cycles -> snap_energy_nj=3000 held stable while energy_nj reaches 8000; snap_ready=1 -> snap_valid low next cycle.
- clear coincident with a sample cycle -> energy_nj=0 and sample_cnt=0 next cycle; a pending snap_valid is retained.
- reset_n low one cycle mid-window with snapshot pending -> all outputs 0 and FSM in IDLE.
